// File: rtl/fm_discriminator_pipe.sv
// fm_discriminator_pipe
//   Pipelined I/Q cross-product FM discriminator. It takes time-multiplexed,
//   channel-tagged offset-binary ADC samples and pairs each I with the Q that
//   follows it. For each pair it computes xq0*xi1 - xi0*xq1 over the current
//   and previous pairs, then emits an offset-binary demodulated sample with a
//   one-cycle valid strobe. Pairing errors are counted in a saturating counter.
//
// Ports
//   clk       : single clock; all state changes on its rising edge
//   rst       : asynchronous, active-high reset
//   en        : sample-accept enable (does not stall the pipeline)
//   in_valid  : channel/X are valid this cycle
//   channel   : tag for X (I_CH, Q_CH, anything else is ignored)
//   X         : ADC sample, offset binary
//   out_valid : one-cycle strobe, out carries a new sample
//   out       : demodulated sample, offset binary; holds between strobes
//   err_cnt   : saturating count of pairing errors
//
// Build option
//   FM_DISC_SAT_EN : when defined, the output stage clamps to the OUT_W range
//                    instead of wrapping.
module fm_discriminator_pipe #(
  parameter int              IN_W  = 10,
  parameter int              OUT_W = 10,
  parameter int              SHIFT = 2,
  parameter int              CH_W  = 3,
  parameter logic [CH_W-1:0] I_CH  = 3'b110,
  parameter logic [CH_W-1:0] Q_CH  = 3'b100,
  parameter int              ERR_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             in_valid,
  input  logic [CH_W-1:0]  channel,
  input  logic [IN_W-1:0]  X,
  output logic             out_valid,
  output logic [OUT_W-1:0] out,
  output logic [ERR_W-1:0] err_cnt
);

  localparam int P_W = 2 * IN_W;
  localparam int D_W = 2 * IN_W + 1;
  localparam int SH  = 2 * IN_W - OUT_W - SHIFT;

  // A negative shift or identical tags would make the block meaningless.
  generate
    if (2 * IN_W < OUT_W + SHIFT) begin : g_bad_width
      $error("fm_discriminator_pipe: 2*IN_W must be >= OUT_W + SHIFT");
    end
    if (I_CH == Q_CH) begin : g_bad_tags
      $error("fm_discriminator_pipe: I_CH and Q_CH must differ");
    end
  endgenerate

  typedef enum logic {WAIT_I, WAIT_Q} state_t;

  state_t state, state_next;

  logic                   accept, is_i, is_q;
  logic                   latch_i, complete_pair, pair_err;
  logic signed [IN_W-1:0] x;

  logic signed [IN_W-1:0] xi_new, xi0, xq0, xi1, xq1;
  logic                   primed;
  logic                   tok_h, tok_1, tok_2;

  logic signed [P_W-1:0]  xq0_e, xi1_e, xi0_e, xq1_e;
  logic signed [P_W-1:0]  p_a, p_b;
  logic signed [D_W-1:0]  d;
  logic [OUT_W-1:0]       s_lim;

  assign accept = en & in_valid;
  assign is_i   = accept && (channel == I_CH);
  assign is_q   = accept && (channel == Q_CH);

  // Subtracting the mid-scale offset is just an MSB flip.
  assign x = {~X[IN_W-1], X[IN_W-2:0]};

  // Pairing state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= WAIT_I;
    end else begin
      state <= state_next;
    end
  end

  // Pairing decisions. A stray Q while waiting for I is dropped; a second I
  // while waiting for Q replaces the pending one. Both count as errors.
  always_comb begin
    state_next    = state;
    latch_i       = 1'b0;
    complete_pair = 1'b0;
    pair_err      = 1'b0;
    case (state)
      WAIT_I: begin
        if (is_i) begin
          latch_i    = 1'b1;
          state_next = WAIT_Q;
        end else if (is_q) begin
          pair_err = 1'b1;
        end
      end
      WAIT_Q: begin
        if (is_q) begin
          complete_pair = 1'b1;
          state_next    = WAIT_I;
        end else if (is_i) begin
          latch_i  = 1'b1;
          pair_err = 1'b1;
        end
      end
      default: state_next = WAIT_I;
    endcase
  end

  // Pair history. The first pair after reset only fills the history, so its
  // token is suppressed through the primed flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      xi_new <= '0;
      xi0    <= '0;
      xq0    <= '0;
      xi1    <= '0;
      xq1    <= '0;
      primed <= 1'b0;
      tok_h  <= 1'b0;
    end else begin
      tok_h <= complete_pair & primed;
      if (latch_i) begin
        xi_new <= x;
      end
      if (complete_pair) begin
        xi1    <= xi0;
        xq1    <= xq0;
        xi0    <= xi_new;
        xq0    <= x;
        primed <= 1'b1;
      end
    end
  end

  assign xq0_e = {{IN_W{xq0[IN_W-1]}}, xq0};
  assign xi1_e = {{IN_W{xi1[IN_W-1]}}, xi1};
  assign xi0_e = {{IN_W{xi0[IN_W-1]}}, xi0};
  assign xq1_e = {{IN_W{xq1[IN_W-1]}}, xq1};

  // S1 cross products and S2 difference. The data registers only load when a
  // token is present, so they hold still between pairs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tok_1 <= 1'b0;
      tok_2 <= 1'b0;
      p_a   <= '0;
      p_b   <= '0;
      d     <= '0;
    end else begin
      tok_1 <= tok_h;
      tok_2 <= tok_1;
      if (tok_h) begin
        p_a <= xq0_e * xi1_e;
        p_b <= xi0_e * xq1_e;
      end
      if (tok_1) begin
        d <= {p_a[P_W-1], p_a} - {p_b[P_W-1], p_b};
      end
    end
  end

`ifdef FM_DISC_SAT_EN
  localparam logic signed [D_W-1:0] S_MAX = {{(D_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [D_W-1:0] S_MIN = {{(D_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

  logic signed [D_W-1:0] s;

  assign s = d >>> SH;

  // Out-of-range results pin to the signed OUT_W extremes.
  always_comb begin
    s_lim = s[OUT_W-1:0];
    if (s > S_MAX) begin
      s_lim = S_MAX[OUT_W-1:0];
    end else if (s < S_MIN) begin
      s_lim = S_MIN[OUT_W-1:0];
    end
  end
`else
  // Only the low OUT_W bits survive, giving a two's-complement wrap.
  assign s_lim = OUT_W'(d >>> SH);
`endif

  // S3 output register. Adding the mid-scale offset is an MSB flip.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out       <= {1'b1, {(OUT_W-1){1'b0}}};
    end else begin
      out_valid <= tok_2;
      if (tok_2) begin
        out <= {~s_lim[OUT_W-1], s_lim[OUT_W-2:0]};
      end
    end
  end

  // Pairing-error counter, sticks at all-ones.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_cnt <= '0;
    end else if (pair_err && (err_cnt != '1)) begin
      err_cnt <= err_cnt + {{(ERR_W-1){1'b0}}, 1'b1};
    end
  end

endmodule

// File: tb/tb_fm_discriminator_pipe.sv
// tb_fm_discriminator_pipe
//   Directed bench for fm_discriminator_pipe at default parameters. A
//   behavioural pairing model pushes expected samples (with the cycle they are
//   due) into a scoreboard queue; a monitor pops them on every strobe.
module tb_fm_discriminator_pipe;

  localparam logic [2:0] I_T = 3'b110;
  localparam logic [2:0] Q_T = 3'b100;
  localparam int         SH  = 8;
`ifdef FM_DISC_SAT_EN
  localparam int OVF_EXP = 1023;
`else
  localparam int OVF_EXP = 508;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0;
  logic       in_valid = 1'b0;
  logic [2:0] channel = 3'b000;
  logic [9:0] X = 10'd0;
  logic       out_valid;
  logic [9:0] out;
  logic [7:0] err_cnt;

  fm_discriminator_pipe #(
    .IN_W(10), .OUT_W(10), .SHIFT(2), .CH_W(3),
    .I_CH(3'b110), .Q_CH(3'b100), .ERR_W(8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .en(en),
    .in_valid(in_valid),
    .channel(channel),
    .X(X),
    .out_valid(out_valid),
    .out(out),
    .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         cyc;
    logic [9:0] val;
  } exp_t;

  exp_t sb[$];

  int         n_checks = 0;
  int         n_fail = 0;
  int         n_strobes = 0;
  logic [9:0] last_out = 10'd0;

  // Behavioural pairing model state.
  bit m_wait_q = 1'b0;
  bit m_primed = 1'b0;
  int m_xi_new = 0, m_xi0 = 0, m_xq0 = 0, m_xi1 = 0, m_xq1 = 0;
  int m_err = 0;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    n_checks++;
    assert (observed === expected)
    else begin
      n_fail++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  function automatic logic [9:0] expOut(int a_xq0, int a_xi1, int a_xi0, int a_xq1);
    int d, s;
    d = a_xq0 * a_xi1 - a_xi0 * a_xq1;
    s = d >>> SH;
`ifdef FM_DISC_SAT_EN
    if (s > 511) s = 511;
    if (s < -512) s = -512;
`endif
    return 10'((s + 512) & 1023);
  endfunction

  task automatic modelReset();
    m_wait_q = 1'b0;
    m_primed = 1'b0;
    m_xi_new = 0; m_xi0 = 0; m_xq0 = 0; m_xi1 = 0; m_xq1 = 0;
    m_err = 0;
    sb.delete();
  endtask

  task automatic errInc();
    if (m_err < 255) m_err++;
  endtask

  // Drive one cycle of input at the falling edge; the sample is accepted at
  // the next rising edge, so its result is due three edges after that.
  task automatic applyStimulus(input logic e, input logic v, input logic [2:0] ch,
                               input logic [9:0] xv);
    int   xc;
    exp_t t;
    @(negedge clk);
    en = e; in_valid = v; channel = ch; X = xv;
    if (e && v) begin
      xc = int'(xv) - 512;
      if (ch == I_T) begin
        if (m_wait_q) errInc();
        m_xi_new = xc;
        m_wait_q = 1'b1;
      end else if (ch == Q_T) begin
        if (!m_wait_q) begin
          errInc();
        end else begin
          m_xi1 = m_xi0; m_xq1 = m_xq0;
          m_xi0 = m_xi_new; m_xq0 = xc;
          if (m_primed) begin
            t.cyc = cyc + 4;
            t.val = expOut(m_xq0, m_xi1, m_xi0, m_xq1);
            sb.push_back(t);
          end
          m_primed = 1'b1;
          m_wait_q = 1'b0;
        end
      end
    end
  endtask

  task automatic idle(input int n);
    repeat (n) applyStimulus(1'b1, 1'b0, 3'b000, 10'd0);
  endtask

  task automatic pair(input logic [9:0] iv, input logic [9:0] qv);
    applyStimulus(1'b1, 1'b1, I_T, iv);
    applyStimulus(1'b1, 1'b1, Q_T, qv);
  endtask

  // Reset lands mid-cycle; its effect on the outputs must be immediate.
  task automatic doReset();
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    checkOutput("rst_out", 32'(out), 32'd512);
    checkOutput("rst_valid", 32'(out_valid), 32'd0);
    checkOutput("rst_err", 32'(err_cnt), 32'd0);
    modelReset();
    en = 1'b0; in_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // Scoreboard monitor.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && out_valid) begin
      n_strobes++;
      last_out = out;
      if (sb.size() == 0) begin
        checkOutput("unexpected_strobe", 32'(sb.size()), 32'd1);
      end else begin
        e = sb.pop_front();
        checkOutput("strobe_cycle", 32'(cyc), 32'(e.cyc));
        checkOutput("out_value", 32'(out), 32'(e.val));
      end
    end
  end

  initial begin
    int s0;

    // Reset state
    doReset();

    // Nominal pair
    $display("[TB] nominal pair");
    s0 = n_strobes;
    pair(10'd612, 10'd512);
    pair(10'd512, 10'd612);
    idle(6);
    checkOutput("nominal_strobes", 32'(n_strobes - s0), 32'd1);
    checkOutput("nominal_out", 32'(last_out), 32'd551);
    checkOutput("nominal_sb_empty", 32'(sb.size()), 32'd0);
    checkOutput("nominal_hold", 32'(out), 32'd551);

    // Overflow
    $display("[TB] overflow");
    s0 = n_strobes;
    pair(10'd1023, 10'd512);
    pair(10'd512, 10'd1023);
    idle(6);
    checkOutput("ovf_strobes", 32'(n_strobes - s0), 32'd2);
    checkOutput("ovf_out", 32'(last_out), 32'(OVF_EXP));
    checkOutput("ovf_sb_empty", 32'(sb.size()), 32'd0);

    // Pairing errors
    $display("[TB] pairing errors");
    doReset();
    s0 = n_strobes;
    applyStimulus(1'b1, 1'b1, Q_T, 10'd600);
    applyStimulus(1'b1, 1'b1, I_T, 10'd700);
    applyStimulus(1'b1, 1'b1, I_T, 10'd612);
    applyStimulus(1'b1, 1'b1, Q_T, 10'd512);
    applyStimulus(1'b1, 1'b1, 3'b000, 10'd900);
    idle(1);
    checkOutput("perr_cnt", 32'(err_cnt), 32'd2);
    checkOutput("perr_model", 32'(err_cnt), 32'(m_err));
    pair(10'd512, 10'd612);
    applyStimulus(1'b1, 1'b1, Q_T, 10'd300);
    idle(6);
    checkOutput("perr_cnt_overlap", 32'(err_cnt), 32'd3);
    checkOutput("perr_strobes", 32'(n_strobes - s0), 32'd1);
    checkOutput("perr_out", 32'(last_out), 32'd551);
    checkOutput("perr_sb_empty", 32'(sb.size()), 32'd0);

    // Streaming with an enable gap
    $display("[TB] streaming");
    doReset();
    s0 = n_strobes;
    for (int i = 0; i < 100; i++) begin
      if (i == 50) begin
        for (int k = 0; k < 5; k++) begin
          applyStimulus(1'b0, 1'b1, (k % 2 == 0) ? Q_T : I_T, 10'($urandom_range(0, 1023)));
        end
      end
      pair(10'($urandom_range(0, 1023)), 10'($urandom_range(0, 1023)));
    end
    idle(6);
    checkOutput("stream_strobes", 32'(n_strobes - s0), 32'd99);
    checkOutput("stream_err", 32'(err_cnt), 32'd0);
    checkOutput("stream_sb_empty", 32'(sb.size()), 32'd0);

    // Reset while tokens are in flight
    $display("[TB] reset mid-stream");
    pair(10'd700, 10'd300);
    pair(10'd400, 10'd800);
    doReset();
    s0 = n_strobes;
    idle(6);
    checkOutput("midrst_no_strobe", 32'(n_strobes - s0), 32'd0);
    pair(10'd612, 10'd512);
    idle(4);
    checkOutput("midrst_primed", 32'(n_strobes - s0), 32'd0);
    pair(10'd512, 10'd612);
    idle(6);
    checkOutput("midrst_strobes", 32'(n_strobes - s0), 32'd1);
    checkOutput("midrst_out", 32'(last_out), 32'd551);

    // Counter saturation
    $display("[TB] error counter saturation");
    doReset();
    repeat (300) applyStimulus(1'b1, 1'b1, Q_T, 10'($urandom_range(0, 1023)));
    idle(1);
    checkOutput("sat_err", 32'(err_cnt), 32'd255);
    checkOutput("sat_model", 32'(err_cnt), 32'(m_err));
    idle(2);
    checkOutput("sat_sb_empty", 32'(sb.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fm_discriminator_pipe.md
# fm_discriminator_pipe

Parametrised, pipelined I/Q cross-product FM discriminator. It accepts time-multiplexed, channel-tagged offset-binary ADC samples, pairs each I with the following Q, and computes `xq0*xi1 - xi0*xq1` over the current and previous pairs. It emits an offset-binary demodulated sample with a valid strobe. The block sits between the ADC channel sequencer and the audio decimation/DAC path, and adds pairing-error tracking and an optional saturating output stage.

## Interface
- `IN_W`, 10: ADC sample width, offset binary.
- `OUT_W`, 10: output width, offset binary.
- `SHIFT`, 2: output gain, as a power of two.
- `CH_W`, 3: channel tag width.
- `I_CH`, 3'b110: tag value for I samples.
- `Q_CH`, 3'b100: tag value for Q samples.
- `ERR_W`, 8: width of the pairing-error counter.
- `clk`  in  1: the single clock; all state changes on its rising edge.
- `rst`  in  1: asynchronous, active-high reset.
- `en`  in  1: sample-accept enable.
- `in_valid`  in  1: `X`/`channel` are valid this cycle.
- `channel`  in  CH_W: tag for `X`.
- `X`  in  IN_W: ADC sample.
- `out_valid`  out  1: one-cycle strobe; `out` is new.
- `out`  out  OUT_W: demodulated sample, offset binary.
- `err_cnt`  out  ERR_W: saturating count of pairing errors.

## Operation
- Sample accepted when `en & in_valid`. Tags other than I_CH/Q_CH are ignored, with no error.
- Centring: `x = X - 2^(IN_W-1)`, interpreted as signed IN_W.
- Pairing FSM:
  - WAIT_I, I accepted: latch `xi_new`, go to WAIT_Q.
  - WAIT_I, Q accepted: discard the sample, `err_cnt++`, stay in WAIT_I.
  - WAIT_Q, Q accepted: complete the pair.
    - Shift history: `xi1<=xi0`, `xq1<=xq0`, `xi0<=xi_new`, `xq0<=x`.
    - Issue a pipeline token; go to WAIT_I.
  - WAIT_Q, I accepted: overwrite `xi_new`, `err_cnt++`, stay in WAIT_Q.
- Priming: the first completed pair after reset loads history only; its token is suppressed and produces no `out_valid`. Every later pair produces exactly one output.
- Pipeline, one token in flight per stage:
  - S1: `p_a = xq0*xi1`, `p_b = xi0*xq1`, each signed 2*IN_W.
  - S2: `d = p_a - p_b`, signed 2*IN_W+1.
  - S3: `s = d >>> (2*IN_W - OUT_W - SHIFT)` (arithmetic); limit to OUT_W (see Configuration); `out = s_lim + 2^(OUT_W-1)`, modulo 2^OUT_W.
- `out` holds its last value between strobes.
- `err_cnt` saturates at 2^ERR_W-1 and never wraps.
- `en=0` blocks acceptance only. Tokens already in S1–S3 still drain and strobe.
- Parameter legality: require `2*IN_W >= OUT_W + SHIFT` and `I_CH != Q_CH`.

## Timing
- Reset values:
  - `out` = 2^(OUT_W-1), i.e. 512 at defaults.
  - `out_valid` = 0, `err_cnt` = 0.
  - FSM = WAIT_I, priming flag cleared.
  - All history, pipeline and token registers = 0.
- Latency: a completing Q accepted at edge t makes `out`/`out_valid` update at edge t+3. `out_valid` is high for exactly one cycle.
- Throughput: one output per I/Q pair. Back-to-back pairs (I,Q,I,Q on consecutive cycles) produce strobes two cycles apart, with no stall and no loss.
- Reset asserted mid-operation clears in-flight tokens immediately. No `out_valid` occurs for pairs accepted before reset. Priming restarts.
- Simultaneous events:
  - A pair error and an in-flight output in the same cycle are independent; both take effect.
  - `err_cnt` increments at most once per cycle.

## Configuration
- `FM_DISC_SAT_EN`, defined: S3 clamps `s` to [-2^(OUT_W-1), 2^(OUT_W-1)-1] before the offset is added, so out-of-range results pin to `out` = 0 or 2^OUT_W-1.
- Undefined: S3 keeps the low OUT_W bits of `s` (two's-complement wrap), with no clamp logic.

## Test plan
- Reset check: assert `rst` asynchronously mid-cycle -> `out`=512, `out_valid`=0, `err_cnt`=0 immediately; no strobe until two full pairs after release.
- Nominal pair:
  - Stimulus: pairs (I=612,Q=512) then (I=512,Q=612), tags 110/100.
  - Response: `out_valid` exactly once, 3 cycles after the second Q; `out`=551 (d=10000, >>>8 = 39).
- Overflow:
  - Stimulus: pairs (I=1023,Q=512) then (I=512,Q=1023).
  - Response: d=261121, s=1020; without `FM_DISC_SAT_EN` `out`=508; with it `out`=1023.
- Pairing errors:
  - Stimulus: sequence Q, I, I, Q, then a tag-000 sample.
  - Response: `err_cnt`=2; one pair formed, using the second I; the 000 sample is ignored.
- Streaming and enable:
  - 100 back-to-back pairs -> 99 strobes, spaced every 2 cycles.
  - Drop `en` for 5 cycles mid-stream -> in-flight strobes still appear, and samples offered during those cycles are not counted.
- Counter saturation: 300 lone Q samples -> `err_cnt` stops at 255.
